// File: rtl/key_pulse_debouncer.sv
// Push-key debouncer with a stability window and press/release strobes.
// value_in is synchronized, and each level change must hold for DELAY_CYCLES samples.
`timescale 1ns/1ps
module key_pulse_debouncer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TIME_DELAY  = 500
) (
  input  logic clk,
  input  logic rstN,
  input  logic value_in,
  output logic value_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * TIME_DELAY;
  localparam int CW = $clog2(DELAY_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_HIGH,
    PRESS_CHK,
    LOW_HELD,
    RELEASE_CHK
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_sync0;
  logic          r_sync1;
  logic          r_value_out;
  logic          r_press;
  logic          r_release;
  logic          w_press;
  logic          w_release;

  assign value_out     = r_value_out;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_press   = 1'b0;
    w_release = 1'b0;
    unique case (r_state)
      IDLE_HIGH: begin
        if (!r_sync1) w_next = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (r_sync1) begin
          w_next = IDLE_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_next  = LOW_HELD;
          w_press = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      LOW_HELD: begin
        if (r_sync1) w_next = RELEASE_CHK;
      end
      RELEASE_CHK: begin
        if (!r_sync1) begin
          w_next = LOW_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_next    = IDLE_HIGH;
          w_release = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_next = IDLE_HIGH;
    endcase
    // every state change restarts the stability window
    if (w_next != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_sync0     <= 1'b1;
      r_sync1     <= 1'b1;
      r_state     <= IDLE_HIGH;
      r_cnt       <= '0;
      r_value_out <= 1'b1;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      r_sync0   <= value_in;
      r_sync1   <= r_sync0;
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      if (w_press) r_value_out <= 1'b0;
      else if (w_release) r_value_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_pulse_debouncer.sv
// Bench for key_pulse_debouncer: run-length reference model plus
// directed latency/glitch/reset cases and randomized key bouncing.
`timescale 1ns/1ps
module tb_key_pulse_debouncer;

  localparam int D = 4;

  logic clk;
  logic rstN;
  logic value_in;
  logic value_out;
  logic press_pulse;
  logic release_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int n_press = 0;
  int n_rel = 0;
  int p0;
  int r0;
  int len;

  key_pulse_debouncer #(
    .CLK_FREQ_HZ(4000),
    .TIME_DELAY (1)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .value_in     (value_in),
    .value_out    (value_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: output flips once the synchronized input has disagreed
  // with it for D+1 consecutive samples.
  logic [1:0] m_hist = 2'b11;
  int         m_run = 0;
  logic       m_out = 1'b1;
  logic       m_press = 1'b0;
  logic       m_rel = 1'b0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_hist  <= 2'b11;
      m_run   <= 0;
      m_out   <= 1'b1;
      m_press <= 1'b0;
      m_rel   <= 1'b0;
    end else begin
      if (m_hist[1] != m_out && m_run == D) begin
        m_out   <= ~m_out;
        m_press <= m_out;
        m_rel   <= ~m_out;
        m_run   <= 0;
      end else begin
        m_press <= 1'b0;
        m_rel   <= 1'b0;
        m_run   <= (m_hist[1] != m_out) ? m_run + 1 : 0;
      end
      m_hist <= {m_hist[0], value_in};
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare against the model mid-cycle, then step past the edge.
  task automatic tick();
    @(negedge clk);
    chk("model value_out", value_out, m_out);
    chk("model press_pulse", press_pulse, m_press);
    chk("model release_pulse", release_pulse, m_rel);
    if (press_pulse) n_press++;
    if (release_pulse) n_rel++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    value_in = 1'b1;
    repeat (3) tick();
    chk("reset value_out", value_out, 1);
    chk("reset press", press_pulse, 0);
    chk("reset release", release_pulse, 0);
    rstN = 1'b1;

    repeat (20) tick();
    chk("idle value_out", value_out, 1);
    chk("idle press count", n_press, 0);
    chk("idle release count", n_rel, 0);

    p0 = n_press;
    value_in = 1'b0;
    repeat (6) tick();
    chk("press before E6", value_out, 1);
    tick();
    chk("press at E6 value_out", value_out, 0);
    chk("press at E6 pulse", press_pulse, 1);
    tick();
    chk("press at E7 pulse", press_pulse, 0);
    repeat (92) tick();
    chk("long hold press count", n_press - p0, 1);
    chk("long hold value_out", value_out, 0);

    r0 = n_rel;
    value_in = 1'b1;
    repeat (2) tick();
    value_in = 1'b0;
    tick();
    value_in = 1'b1;
    repeat (6) tick();
    chk("release before E6", value_out, 0);
    tick();
    chk("release at E6 value_out", value_out, 1);
    chk("release at E6 pulse", release_pulse, 1);
    repeat (10) tick();
    chk("release count", n_rel - r0, 1);

    p0 = n_press;
    r0 = n_rel;
    value_in = 1'b0;
    repeat (3) tick();
    value_in = 1'b1;
    repeat (20) tick();
    chk("glitch value_out", value_out, 1);
    chk("glitch press count", n_press - p0, 0);
    chk("glitch release count", n_rel - r0, 0);

    value_in = 1'b0;
    repeat (5) tick();
    rstN = 1'b0;
    #1;
    chk("mid reset value_out", value_out, 1);
    chk("mid reset press", press_pulse, 0);
    chk("mid reset release", release_pulse, 0);
    #1;
    tick();
    rstN = 1'b1;
    repeat (6) tick();
    chk("post reset before E6", value_out, 1);
    tick();
    chk("post reset at E6", value_out, 0);
    chk("post reset press", press_pulse, 1);

    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
      end
      value_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      repeat (len) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_pulse_debouncer.md
KEY_PULSE_DEBOUNCER -- requirements
Module: key_pulse_debouncer

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter TIME_DELAY, default 500, meaning the debounce stability window in ms.
REQ-003 The block SHALL derive local constant DELAY_CYCLES = CLK_FREQ_HZ/1000*TIME_DELAY (integer); legal range >= 1.
REQ-004 Port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 Port rstN, input, 1, reset, asynchronous assert and active-low.
REQ-006 Port value_in, input, 1, raw asynchronous push-key level (1 = released, 0 = pressed).
REQ-007 Port value_out, output, 1, debounced key level, registered, same polarity as value_in.
REQ-008 Port press_pulse, output, 1, one-cycle registered strobe on each accepted press (value_out 1->0).
REQ-009 Port release_pulse, output, 1, one-cycle registered strobe on each accepted release (value_out 0->1).

Function
REQ-010 value_in SHALL pass through a 2-flop synchronizer; sync_in (second flop) SHALL be the only sampled copy of the input.
REQ-011 The FSM SHALL have exactly four states: IDLE_HIGH, PRESS_CHK, LOW_HELD, RELEASE_CHK.
REQ-012 The stability counter cnt SHALL be $clog2(DELAY_CYCLES+1) bits wide and SHALL clear on every state transition.
REQ-013 IDLE_HIGH: sync_in==0 -> PRESS_CHK; otherwise stay.
REQ-014 PRESS_CHK: sync_in==1 -> IDLE_HIGH (glitch rejected, no output change); sync_in==0 and cnt==DELAY_CYCLES-1 -> LOW_HELD; otherwise cnt increments.
REQ-015 LOW_HELD: sync_in==1 -> RELEASE_CHK; otherwise stay.
REQ-016 RELEASE_CHK: sync_in==0 -> LOW_HELD; sync_in==1 and cnt==DELAY_CYCLES-1 -> IDLE_HIGH; otherwise cnt increments.
REQ-017 On the edge entering LOW_HELD from PRESS_CHK, value_out SHALL become 0 and press_pulse SHALL be 1 for exactly the following cycle.
REQ-018 On the edge entering IDLE_HIGH from RELEASE_CHK, value_out SHALL become 1 and release_pulse SHALL be 1 for exactly the following cycle.
REQ-019 Latency: with value_in stable from sampling edge E0, value_out SHALL change at edge E0+DELAY_CYCLES+2.
REQ-020 value_out SHALL change only on the transitions in REQ-017/REQ-018; press_pulse and release_pulse SHALL never be 1 in the same cycle.
REQ-021 A key held indefinitely SHALL produce exactly one press_pulse; cnt SHALL never exceed DELAY_CYCLES-1 (no wrap).
REQ-022 With DELAY_CYCLES==1, a single sync_in sample in the CHK state SHALL suffice to accept the change.

Reset
REQ-023 While rstN==0: both synchronizer flops = 1, state = IDLE_HIGH, cnt = 0, value_out = 1, press_pulse = 0, release_pulse = 0.
REQ-024 Reset asserted mid-check or mid-hold SHALL abort immediately; after release a full DELAY_CYCLES+2 stable window SHALL be required again.

Verification (CLK_FREQ_HZ=4000, TIME_DELAY=1 -> DELAY_CYCLES=4)
REQ-025 Reset release, value_in=1 for 20 cycles -> value_out=1, both pulses 0 throughout.
REQ-026 value_in=0 from edge E0, held -> value_out=0 after E6, press_pulse=1 only between E6 and E7.
REQ-027 value_in=0 for 3 cycles then 1 -> value_out stays 1, no pulses, FSM back in IDLE_HIGH.
REQ-028 From LOW_HELD, value_in 1 for 2 cycles, 0 for 1 cycle, then 1 stable -> one release_pulse, value_out=1 only 6 edges after the last 0->1.
REQ-029 rstN low for 1 cycle during PRESS_CHK (cnt=2) with value_in held 0 -> outputs reset values; value_out falls 6 edges after rstN rises.
REQ-030 value_in=0 for 100 cycles -> exactly one press_pulse, value_out=0 from E6 onward.
